// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, selects the next PC, and registers the fetched word into IF/ID.
// Latency: one edge from pc == A to the word at A on if_id_instr; stall holds PC and IF/ID, flush bubbles IF/ID.
module instruction_fetch_stage #(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              IMEM_WORDS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic             if_id_valid,
    output logic             misaligned_fault,
    output logic             range_fault
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic             range_q, range_d;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] next_pc;
    logic             redirect;
    logic             misaligned;
    logic             out_of_range;

    assign seq_pc       = pc_q + WIDTH'(4);
    assign redirect     = (pc_src != 2'b00);
    assign out_of_range = (pc_q[WIDTH-1:2] >= (WIDTH-2)'(IMEM_WORDS));

    always_comb begin
        redirect_target = seq_pc;
        case (pc_src)
            2'b01:   redirect_target = branch_target;
            // Jump region comes from the PC+4 of the instruction sitting in ID.
            2'b10:   redirect_target = {pc4_q[WIDTH-1:WIDTH-4], jump_index, 2'b00};
            2'b11:   redirect_target = jr_target;
            default: redirect_target = seq_pc;
        endcase
    end

    assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
    assign next_pc    = redirect ? {redirect_target[WIDTH-1:2], 2'b00} : seq_pc;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        range_d = range_q;

        // A stalled redirect is not consumed, so it cannot raise the alignment fault yet.
        if (!stall) begin
            pc_d = next_pc;
            if (misaligned) begin
                mis_d = 1'b1;
            end
        end

        if (flush) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
        end else if (out_of_range) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
            range_d = 1'b1;
        end else begin
            instr_d = imem_data;
            pc4_d   = seq_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            range_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            range_q <= range_d;
        end
    end

    assign imem_addr        = pc_q;
    assign if_id_instr      = instr_q;
    assign if_id_pc_plus4   = pc4_q;
    assign if_id_valid      = valid_q;
    assign misaligned_fault = mis_q;
    assign range_fault      = range_q;

endmodule
